sd_tagfifo2: RTL

Source-tagged elastic buffer placed directly downstream of the 2-input weighted-round-robin mux. Captures each granted transfer (data plus one-hot grant) into a small FIFO and re-presents it on a srdy/drdy producer port with a 1-bit source tag. Keeps per-source occupancy counts so the consumer can attribute traffic to the arbitration source. Flags a sticky error on any malformed grant.

---
 rtl/sd_pkg.sv | 6 +
 rtl/sd_tagfifo2_cnt.sv | 18 +
 rtl/sd_tagfifo2.sv | 78 +++++++
 3 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: source tag type and encodings shared between the WRR mux and downstream buffers
package sd_pkg;
  typedef logic sd_src_t;
  localparam sd_src_t SD_SRC0 = 1'b0;
  localparam sd_src_t SD_SRC1 = 1'b1;
endpackage

// File: rtl/sd_tagfifo2_cnt.sv
// sd_tagfifo2_cnt: up/down occupancy counter
//   clk, reset (async active-low), inc/dec (same-cycle pair cancels), cnt (current count)
module sd_tagfifo2_cnt #(
  parameter int w = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [w-1:0] cnt
);
  logic [w-1:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + {{(w-1){1'b0}}, inc} - {{(w-1){1'b0}}, dec};
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/sd_tagfifo2.sv
// sd_tagfifo2: source-tagged elastic FIFO behind the 2-input WRR mux
//   c_*  : consumer side from the mux (data, one-hot grant, srdy/drdy)
//   p_*  : producer side (head data, 1-bit source tag, srdy/drdy)
//   occ0/occ1/usage : per-source and total entry counts
//   grant_err : sticky, set when a written grant is not one-hot
module sd_tagfifo2
  import sd_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 4,
  parameter int asz   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] c_data,
  input  logic [1:0]       c_grant,
  input  logic             c_srdy,
  output logic             c_drdy,
  output logic [width-1:0] p_data,
  output sd_src_t          p_tag,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [asz:0]     occ0,
  output logic [asz:0]     occ1,
  output logic [asz:0]     usage,
  output logic             grant_err
);
  logic [width-1:0] mem_q [depth];
  sd_src_t          tag_q [depth];
  logic [asz:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d, wr_en, rd_en, full, empty;
  // extra pointer MSB distinguishes full from empty when the low bits match
  assign empty  = wr_ptr_q == rd_ptr_q;
  assign full   = (wr_ptr_q[asz-1:0] == rd_ptr_q[asz-1:0]) && (wr_ptr_q[asz] != rd_ptr_q[asz]);
  assign c_drdy = !full;
  assign p_srdy = !empty;
  assign wr_en  = c_srdy & c_drdy;
  assign rd_en  = p_srdy & p_drdy;
  assign p_data = mem_q[rd_ptr_q[asz-1:0]];
  assign p_tag  = tag_q[rd_ptr_q[asz-1:0]];
  assign usage  = wr_ptr_q - rd_ptr_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + (asz+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (asz+1)'(rd_en);
    err_d    = err_q | (wr_en & (c_grant[0] == c_grant[1]));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= SD_SRC0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      if (wr_en) begin
        mem_q[wr_ptr_q[asz-1:0]] <= c_data;
        tag_q[wr_ptr_q[asz-1:0]] <= c_grant[1];
      end
    end
  assign grant_err = err_q;
  sd_tagfifo2_cnt #(.w(asz+1)) u_cnt0 (
    .clk(clk), .reset(reset),
    .inc(wr_en & (c_grant[1] == SD_SRC0)),
    .dec(rd_en & (p_tag == SD_SRC0)),
    .cnt(occ0)
  );
  sd_tagfifo2_cnt #(.w(asz+1)) u_cnt1 (
    .clk(clk), .reset(reset),
    .inc(wr_en & (c_grant[1] == SD_SRC1)),
    .dec(rd_en & (p_tag == SD_SRC1)),
    .cnt(occ1)
  );
endmodule
